// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the multicycle RISC-V control unit.
package riscv_ctrl_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I_ALU = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LW    = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_SW    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEM_ADDR, ST_MEM_RD,
    ST_MEM_WR, ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL, ST_TRAP
  } state_e;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT_R = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT_I = 2'b11;

  localparam logic [1:0] ALUB_RS2    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_BR_IMM = 2'b11;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // One-hot instruction class produced by the opcode decoder.
  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic bad;
  } opc_class_t;

  // Datapath control word driven by the FSM.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Maps a 7-bit opcode to a one-hot instruction class; JAL is legal only when enabled.
module opcode_class_decode
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_JAL = 1'b1
) (
  input  logic [OPC_W-1:0] opcode,
  output opc_class_t       opc_class_c
);

  always_comb begin
    opc_class_c = '0;
    case (opcode)
      OPC_R:     opc_class_c.r      = 1'b1;
      OPC_I_ALU: opc_class_c.i      = 1'b1;
      OPC_LW:    opc_class_c.load   = 1'b1;
      OPC_SW:    opc_class_c.store  = 1'b1;
      OPC_BEQ:   opc_class_c.branch = 1'b1;
      OPC_JAL: begin
        if (ENABLE_JAL) opc_class_c.jal = 1'b1;
        else            opc_class_c.bad = 1'b1;
      end
      default:   opc_class_c.bad    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback,
// traps illegal opcodes and counts retired instructions.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          ENABLE_JAL    = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state, state_nxt;
  opc_class_t       opc_cls;
  ctrl_t            ctrl_c, ctrl;
  logic             rdy_c;
  logic             retire_c;
  logic [CNT_W-1:0] cnt;
  logic             unused_zero;

  // zero gates PCWriteCond inside the datapath, so the FSM never consumes it.
  assign unused_zero = zero;
  assign rdy_c       = mem_ready | ~MEM_HANDSHAKE;

  opcode_class_decode #(.ENABLE_JAL(ENABLE_JAL)) u_decode (
    .opcode      (opcode),
    .opc_class_c (opc_cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (retire_c) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl_c    = '0;
    retire_c  = 1'b0;
    case (state)
      ST_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = ALUB_FOUR;
        ctrl_c.alu_op    = ALUOP_ADD;
        ctrl_c.pc_source = PCSRC_ALU;
        ctrl_c.ir_write  = rdy_c;
        ctrl_c.pc_write  = rdy_c;
        if (rdy_c) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        ctrl_c.alu_src_b = ALUB_BR_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
        case (1'b1)
          opc_cls.r:                     state_nxt = ST_EXEC_R;
          opc_cls.i:                     state_nxt = ST_EXEC_I;
          opc_cls.load, opc_cls.store:   state_nxt = ST_MEM_ADDR;
          opc_cls.branch:                state_nxt = ST_BRANCH;
          opc_cls.jal:                   state_nxt = ST_JAL;
          opc_cls.bad:                   state_nxt = ST_TRAP;
          default:                       state_nxt = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ALUB_RS2;
        ctrl_c.alu_op    = ALUOP_FUNCT_R;
        state_nxt        = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ALUB_IMM;
        ctrl_c.alu_op    = ALUOP_FUNCT_I;
        state_nxt        = ST_WB_ALU;
      end
      ST_MEM_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ALUB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
        state_nxt        = opc_cls.load ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.i_or_d   = 1'b1;
        if (rdy_c) state_nxt = ST_WB_MEM;
      end
      // MemWrite is held through the wait; the store retires on the ready cycle.
      ST_MEM_WR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.i_or_d    = 1'b1;
        if (rdy_c) begin
          state_nxt = ST_FETCH;
          retire_c  = 1'b1;
        end
      end
      ST_WB_ALU: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = WB_ALUOUT;
        state_nxt         = ST_FETCH;
        retire_c          = 1'b1;
      end
      ST_WB_MEM: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = WB_MDR;
        state_nxt         = ST_FETCH;
        retire_c          = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = ALUB_RS2;
        ctrl_c.alu_op        = ALUOP_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
        state_nxt            = ST_FETCH;
        retire_c             = 1'b1;
      end
      // PC already holds PC+4 from FETCH, so it is the link value.
      ST_JAL: begin
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.pc_source  = PCSRC_ALUOUT;
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = WB_PC;
        state_nxt         = ST_FETCH;
        retire_c          = 1'b1;
      end
      ST_TRAP: begin
        ctrl_c.illegal = 1'b1;
        state_nxt      = ST_TRAP;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Reset silences every strobe in the same cycle, aborting any access in flight.
  assign ctrl    = reset ? '0 : ctrl_c;
  assign retired = reset ? '0 : cnt;

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign illegal     = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle control-word checks against an
// instruction-level phase model, across handshake/JAL/counter-width variants.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } vec_t;

  typedef enum int {P_F, P_D, P_XR, P_XI, P_MA, P_MR, P_MW, P_WA, P_WM, P_BR, P_J, P_T} phase_e;

  typedef struct {
    phase_e ph;
    bit     rdy;
    bit     mem;
    bit     opc;
  } step_t;

  typedef struct {
    logic [6:0] opc;
    bit         zz;
    int         fw;
    int         mw;
    int         exp_irw;
    int         exp_pcw;
    int         exp_mw;
    int         exp_rw;
  } rec_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_JAL = 5, K_BAD = 6;
  localparam int I_MAIN = 0, I_NJ = 1, I_NH = 2, I_W4 = 3;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  wire  [16:0] vm0, vm1, vm2, vm3;
  wire  [31:0] ret0, ret1, ret2;
  wire  [3:0]  ret3;

  int          n_checks;
  int          n_fail;
  int unsigned ret_model;
  step_t       q[$];
  rec_t        tbl[9];
  logic [6:0]  legal[6];

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .ENABLE_JAL(1'b1), .CNT_W(32)) dut_main (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(vm0[16]), .PCWriteCond(vm0[15]), .IorD(vm0[14]), .MemRead(vm0[13]),
    .MemWrite(vm0[12]), .IRWrite(vm0[11]), .MemtoReg(vm0[10:9]), .RegWrite(vm0[8]),
    .ALUSrcA(vm0[7]), .ALUSrcB(vm0[6:5]), .ALUOp(vm0[4:3]), .PCSource(vm0[2:1]),
    .illegal(vm0[0]), .retired(ret0));

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .ENABLE_JAL(1'b0), .CNT_W(32)) dut_nj (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(vm1[16]), .PCWriteCond(vm1[15]), .IorD(vm1[14]), .MemRead(vm1[13]),
    .MemWrite(vm1[12]), .IRWrite(vm1[11]), .MemtoReg(vm1[10:9]), .RegWrite(vm1[8]),
    .ALUSrcA(vm1[7]), .ALUSrcB(vm1[6:5]), .ALUOp(vm1[4:3]), .PCSource(vm1[2:1]),
    .illegal(vm1[0]), .retired(ret1));

  multicycle_control #(.MEM_HANDSHAKE(1'b0), .ENABLE_JAL(1'b1), .CNT_W(32)) dut_nh (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(vm2[16]), .PCWriteCond(vm2[15]), .IorD(vm2[14]), .MemRead(vm2[13]),
    .MemWrite(vm2[12]), .IRWrite(vm2[11]), .MemtoReg(vm2[10:9]), .RegWrite(vm2[8]),
    .ALUSrcA(vm2[7]), .ALUSrcB(vm2[6:5]), .ALUOp(vm2[4:3]), .PCSource(vm2[2:1]),
    .illegal(vm2[0]), .retired(ret2));

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .ENABLE_JAL(1'b1), .CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(vm3[16]), .PCWriteCond(vm3[15]), .IorD(vm3[14]), .MemRead(vm3[13]),
    .MemWrite(vm3[12]), .IRWrite(vm3[11]), .MemtoReg(vm3[10:9]), .RegWrite(vm3[8]),
    .ALUSrcA(vm3[7]), .ALUSrcB(vm3[6:5]), .ALUOp(vm3[4:3]), .PCSource(vm3[2:1]),
    .illegal(vm3[0]), .retired(ret3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t get_vec(int inst);
    case (inst)
      I_MAIN:  return vec_t'(vm0);
      I_NJ:    return vec_t'(vm1);
      I_NH:    return vec_t'(vm2);
      default: return vec_t'(vm3);
    endcase
  endfunction

  function automatic logic [31:0] get_ret(int inst);
    case (inst)
      I_MAIN:  return ret0;
      I_NJ:    return ret1;
      I_NH:    return ret2;
      default: return {28'd0, ret3};
    endcase
  endfunction

  function automatic int kind_of(logic [6:0] o, bit en_jal);
    if (o == 7'b0110011) return K_R;
    if (o == 7'b0010011) return K_I;
    if (o == 7'b0000011) return K_LW;
    if (o == 7'b0100011) return K_SW;
    if (o == 7'b1100011) return K_BEQ;
    if (o == 7'b1101111 && en_jal) return K_JAL;
    return K_BAD;
  endfunction

  // Control word each instruction phase must present, straight from the phase table.
  function automatic vec_t phase_vec(phase_e p, bit rdy);
    vec_t v = '0;
    case (p)
      P_F:  begin v.mem_read = 1; v.alu_src_b = 2'b01; v.ir_write = rdy; v.pc_write = rdy; end
      P_D:  v.alu_src_b = 2'b11;
      P_XR: begin v.alu_src_a = 1; v.alu_src_b = 2'b00; v.alu_op = 2'b10; end
      P_XI: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; v.alu_op = 2'b11; end
      P_MA: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      P_MR: begin v.mem_read = 1; v.i_or_d = 1; end
      P_MW: begin v.mem_write = 1; v.i_or_d = 1; end
      P_WA: v.reg_write = 1;
      P_WM: begin v.reg_write = 1; v.mem_to_reg = 2'b01; end
      P_BR: begin v.alu_src_a = 1; v.alu_op = 2'b01; v.pc_write_cond = 1; v.pc_source = 2'b01; end
      P_J:  begin v.pc_write = 1; v.pc_source = 2'b01; v.reg_write = 1; v.mem_to_reg = 2'b10; end
      P_T:  v.illegal = 1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic void push(phase_e p, bit rdy, bit mem, bit opc);
    step_t s;
    s.ph = p; s.rdy = rdy; s.mem = mem; s.opc = opc;
    q.push_back(s);
  endfunction

  // Expand one instruction into its cycle-by-cycle phase list; returns its retire count.
  function automatic int build(logic [6:0] opc, bit en_jal, int fw, int mw);
    int k = kind_of(opc, en_jal);
    q.delete();
    for (int i = 0; i < fw; i++) push(P_F, 0, 1, 0);
    push(P_F, 1, 1, 0);
    push(P_D, 1, 0, 1);
    case (k)
      K_R:   begin push(P_XR, 1, 0, 0); push(P_WA, 1, 0, 0); end
      K_I:   begin push(P_XI, 1, 0, 0); push(P_WA, 1, 0, 0); end
      K_LW: begin
        push(P_MA, 1, 0, 1);
        for (int i = 0; i < mw; i++) push(P_MR, 0, 1, 0);
        push(P_MR, 1, 1, 0);
        push(P_WM, 1, 0, 0);
      end
      K_SW: begin
        push(P_MA, 1, 0, 1);
        for (int i = 0; i < mw; i++) push(P_MW, 0, 1, 0);
        push(P_MW, 1, 1, 0);
      end
      K_BEQ: push(P_BR, 1, 0, 0);
      K_JAL: push(P_J, 1, 0, 0);
      default: for (int i = 0; i < 20; i++) push(P_T, 1, 0, 0);
    endcase
    return (k == K_BAD) ? 0 : 1;
  endfunction

  task automatic check_vec(input string tag, input int step, input vec_t got, input vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: control word got %h expected %h", tag, step, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'($urandom);
    opcode    = 7'($urandom);
    #1;
    for (int i = 0; i < 4; i++) begin
      check_vec("reset_outputs", i, get_vec(i), '0);
      check_int("reset_retired", get_ret(i), 32'd0);
    end
    @(posedge clk); #1;
    reset     = 1'b0;
    ret_model = 0;
  endtask

  // Drive one instruction (optionally truncated) and compare every cycle of one instance.
  task automatic run(input int inst, input logic [6:0] opc, input bit zz, input int fw,
                     input int mw, input int nmax, input bit force_low, input string tag,
                     output int n_irw, output int n_pcw, output int n_mw, output int n_rw);
    int   del;
    vec_t got;
    del = build(opc, inst != I_NJ, fw, mw);
    n_irw = 0; n_pcw = 0; n_mw = 0; n_rw = 0;
    for (int s = 0; s < q.size() && s < nmax; s++) begin
      opcode    = q[s].opc ? opc : 7'($urandom);
      zero      = (q[s].ph == P_BR) ? zz : 1'($urandom);
      mem_ready = q[s].mem ? (force_low ? 1'b0 : q[s].rdy) : 1'($urandom);
      #1;
      got = get_vec(inst);
      check_vec(tag, s, got, phase_vec(q[s].ph, q[s].rdy));
      n_irw += int'(got.ir_write);
      n_pcw += int'(got.pc_write);
      n_mw  += int'(got.mem_write);
      n_rw  += int'(got.reg_write);
      @(posedge clk); #1;
    end
    if (nmax >= q.size()) begin
      ret_model += del;
      check_int({tag, "_retired"}, get_ret(inst), ret_model);
      if (inst == I_MAIN) check_int({tag, "_retired_w4"}, {28'd0, ret3}, {28'd0, 4'(ret_model)});
    end
  endtask

  initial begin
    int a, b, c, d;
    logic [6:0] bad_opc;
    n_checks = 0; n_fail = 0; ret_model = 0;
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    legal[0] = 7'b0110011; legal[1] = 7'b0010011; legal[2] = 7'b0000011;
    legal[3] = 7'b0100011; legal[4] = 7'b1100011; legal[5] = 7'b1101111;
    //           opc           z  fw mw irw pcw mw rw
    tbl[0] = '{7'b0000011, 1'b0, 2, 3, 1, 1, 0, 1};
    tbl[1] = '{7'b0100011, 1'b0, 0, 4, 1, 1, 5, 0};
    tbl[2] = '{7'b1100011, 1'b1, 0, 0, 1, 1, 0, 0};
    tbl[3] = '{7'b1100011, 1'b0, 0, 0, 1, 1, 0, 0};
    tbl[4] = '{7'b1101111, 1'b0, 0, 0, 1, 2, 0, 1};
    tbl[5] = '{7'b0110011, 1'b0, 1, 0, 1, 1, 0, 1};
    tbl[6] = '{7'b0010011, 1'b1, 0, 0, 1, 1, 0, 1};
    tbl[7] = '{7'b0100011, 1'b0, 1, 0, 1, 1, 1, 0};
    tbl[8] = '{7'b0000011, 1'b1, 0, 0, 1, 1, 0, 1};
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset during a load wait, then an R-type: writeback lands in cycle 4.
    run(I_MAIN, 7'b0000011, 0, 0, 5, 4, 0, "lw_abort", a, b, c, d);
    do_reset();
    run(I_MAIN, 7'b0110011, 0, 0, 0, 99, 0, "r_after_reset", a, b, c, d);
    check_int("r_after_reset_regwrite_cnt", d, 1);

    // Reset during a store wait must drop MemWrite immediately.
    run(I_MAIN, 7'b0100011, 0, 0, 5, 4, 0, "sw_abort", a, b, c, d);
    do_reset();

    for (int t = 0; t < 9; t++) begin
      run(I_MAIN, tbl[t].opc, tbl[t].zz, tbl[t].fw, tbl[t].mw, 99, 0, $sformatf("tbl%0d", t), a, b, c, d);
      check_int($sformatf("tbl%0d_irwrite_cnt", t), a, tbl[t].exp_irw);
      check_int($sformatf("tbl%0d_pcwrite_cnt", t), b, tbl[t].exp_pcw);
      check_int($sformatf("tbl%0d_memwrite_cnt", t), c, tbl[t].exp_mw);
      check_int($sformatf("tbl%0d_regwrite_cnt", t), d, tbl[t].exp_rw);
    end

    for (int t = 0; t < 150; t++)
      run(I_MAIN, legal[$urandom_range(5, 0)], 1'($urandom), $urandom_range(3, 0),
          $urandom_range(3, 0), 99, 0, "rand", a, b, c, d);

    // Illegal opcode: absorbing trap with illegal held and the counter frozen.
    bad_opc = 7'b0110111;
    for (int t = 0; t < 50 && kind_of(bad_opc, 1) != K_BAD; t++) bad_opc = 7'($urandom);
    if ($urandom_range(1, 0) == 1) begin
      for (int t = 0; t < 50; t++) begin
        bad_opc = 7'($urandom);
        if (kind_of(bad_opc, 1) == K_BAD) break;
        bad_opc = 7'b1101011;
      end
    end
    run(I_MAIN, bad_opc, 0, 1, 0, 99, 0, "trap_main", a, b, c, d);
    check_int("trap_main_strobes", a + c + d, 1);
    do_reset();
    run(I_MAIN, 7'b0010011, 0, 0, 0, 99, 0, "after_trap", a, b, c, d);

    // JAL disabled: same opcode traps.
    do_reset();
    run(I_NJ, 7'b0110011, 0, 0, 0, 99, 0, "nj_r", a, b, c, d);
    run(I_NJ, 7'b1101111, 0, 0, 0, 99, 0, "nj_jal_trap", a, b, c, d);
    check_int("nj_trap_regwrite_cnt", d, 0);

    // No handshake: mem_ready held low must not stall anything.
    do_reset();
    run(I_NH, 7'b0000011, 0, 0, 0, 99, 1, "nh_lw", a, b, c, d);
    run(I_NH, 7'b0100011, 0, 0, 0, 99, 1, "nh_sw", a, b, c, d);
    check_int("nh_sw_memwrite_cnt", c, 1);
    run(I_NH, 7'b0110011, 0, 0, 0, 99, 1, "nh_r", a, b, c, d);

    // Narrow counter wraps after 16 retirements.
    do_reset();
    for (int t = 0; t < 16; t++) begin
      run(I_MAIN, 7'b0110011, 0, 0, 0, 99, 0, "w4_r", a, b, c, d);
      if (t == 14) check_int("w4_at_15", {28'd0, ret3}, 32'd15);
      if (t == 15) check_int("w4_wrapped", {28'd0, ret3}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
